// File: rtl/cpu_ctrl_pkg.sv
// Shared opcodes, state encoding, strobe bundle and small decode helpers
// for the hardwired control sequencer.
package cpu_ctrl_pkg;

  localparam int unsigned OPC_W   = 5;
  localparam int unsigned OPC_MSB = 31;
  localparam int unsigned OPC_LSB = 27;
  localparam int unsigned STEP_W  = 4;

  typedef logic [OPC_W-1:0] opcode_t;

  localparam opcode_t OP_LD   = 5'b00000;
  localparam opcode_t OP_LDI  = 5'b00001;
  localparam opcode_t OP_ST   = 5'b00010;
  localparam opcode_t OP_ADDI = 5'b01100;
  localparam opcode_t OP_IN   = 5'b10110;
  localparam opcode_t OP_OUT  = 5'b10111;
  localparam opcode_t OP_MFHI = 5'b11000;
  localparam opcode_t OP_MFLO = 5'b11001;
  localparam opcode_t OP_NOP  = 5'b11010;
  localparam opcode_t OP_HALT = 5'b11011;

  typedef enum logic [STEP_W-1:0] {
    ST_T0   = 4'd0,
    ST_T1   = 4'd1,
    ST_T2   = 4'd2,
    ST_T3   = 4'd3,
    ST_T4   = 4'd4,
    ST_T5   = 4'd5,
    ST_T6   = 4'd6,
    ST_T7   = 4'd7,
    ST_HALT = 4'd8
  } state_e;

  localparam logic [STEP_W-1:0] STEP_HALT_IDX = 4'd0;

  typedef struct packed {
    logic pc_out;
    logic pc_increment;
    logic pc_enable;
    logic mar_enable;
    logic mdr_enable;
    logic mdr_out;
    logic read;
    logic ram_write;
    logic ir_enable;
    logic y_enable;
    logic z_enable;
    logic zlo_out;
    logic alu_add;
    logic gra;
    logic grb;
    logic grc;
    logic r_in;
    logic r_out;
    logic ba_out;
    logic c_sign_extended_out;
    logic hi_out;
    logic lo_out;
    logic outport_enable;
    logic inport_out;
  } strobes_t;

  // Final T-step of each instruction; unsupported opcodes behave as nop.
  function automatic state_e last_step(input opcode_t op);
    case (op)
      OP_LDI, OP_ADDI:                 return ST_T5;
      OP_LD, OP_ST:                    return ST_T7;
      OP_IN, OP_OUT, OP_MFHI, OP_MFLO: return ST_T3;
      default:                         return ST_T2;
    endcase
  endfunction

  function automatic logic is_legal(input opcode_t op);
    return op inside {OP_LD, OP_LDI, OP_ST, OP_ADDI, OP_IN, OP_OUT,
                      OP_MFHI, OP_MFLO, OP_NOP, OP_HALT};
  endfunction

  function automatic logic [STEP_W-1:0] step_index(input state_e s);
    return (s == ST_HALT) ? STEP_HALT_IDX : STEP_W'(s);
  endfunction

endpackage

// File: rtl/step_timer.sv
// Holds each T-step for CYCLES clocks; freezes while stalled and pulses
// o_term_c on the clock that ends the step.
module step_timer #(
  parameter int unsigned CYCLES = 2
) (
  input  logic clk,
  input  logic clr,
  input  logic i_en,
  input  logic i_stall,
  output logic o_term_c
);

  localparam int unsigned CNT_W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_adv;

  assign w_adv    = i_en && !i_stall;
  assign o_term_c = w_adv && (r_cnt == LAST);

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_cnt <= '0;
    end else if (w_adv) begin
      r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired Moore control unit: fetch T0-T2, opcode-driven execute T3-T7,
// registered datapath strobes, sticky illegal flag and retired counter.
module control_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned STEP_CYCLES = 2,
  parameter int unsigned CNT_W       = 16
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [31:0]       ir,
  input  logic              stall,
  output logic              pc_out,
  output logic              pc_increment,
  output logic              pc_enable,
  output logic              mar_enable,
  output logic              mdr_enable,
  output logic              mdr_out,
  output logic              read,
  output logic              ram_write,
  output logic              ir_enable,
  output logic              y_enable,
  output logic              z_enable,
  output logic              zlo_out,
  output logic              alu_add,
  output logic              gra,
  output logic              grb,
  output logic              grc,
  output logic              r_in,
  output logic              r_out,
  output logic              ba_out,
  output logic              c_sign_extended_out,
  output logic              hi_out,
  output logic              lo_out,
  output logic              outport_enable,
  output logic              inport_out,
  output logic              run,
  output logic              illegal,
  output logic [STEP_W-1:0] step,
  output logic [CNT_W-1:0]  retired
);

  state_e             r_state;
  state_e             w_state_nxt;
  opcode_t            r_op;
  opcode_t            w_op_nxt;
  opcode_t            w_ir_op;
  logic               r_active;
  logic               w_timer_en;
  logic               w_term;
  logic               w_retire;
  logic               w_set_ill;
  strobes_t           r_strb;
  logic               r_run;
  logic               r_ill;
  logic [STEP_W-1:0]  r_step;
  logic [CNT_W-1:0]   r_retired;
  logic               w_unused_ir;

  assign w_ir_op     = ir[OPC_MSB:OPC_LSB];
  assign w_unused_ir = ^ir[OPC_LSB-1:0];

  // The first clock after reset only loads the T0 strobes; timing starts after it.
  assign w_timer_en = r_active && (r_state != ST_HALT);

  step_timer #(
    .CYCLES (STEP_CYCLES)
  ) u_step_timer (
    .clk      (clk),
    .clr      (clr),
    .i_en     (w_timer_en),
    .i_stall  (stall),
    .o_term_c (w_term)
  );

  // Strobe pattern for a given step of a given instruction.
  function automatic strobes_t decode(input state_e s, input opcode_t op);
    strobes_t d;
    d = '0;
    case (s)
      ST_T0: begin
        d.pc_out       = 1'b1;
        d.mar_enable   = 1'b1;
        d.pc_increment = 1'b1;
        d.z_enable     = 1'b1;
      end
      ST_T1: begin
        d.read       = 1'b1;
        d.mdr_enable = 1'b1;
        d.zlo_out    = 1'b1;
        d.pc_enable  = 1'b1;
      end
      ST_T2: begin
        d.mdr_out   = 1'b1;
        d.ir_enable = 1'b1;
      end
      ST_T3: begin
        case (op)
          OP_IN: begin
            d.inport_out = 1'b1;
            d.gra        = 1'b1;
            d.r_in       = 1'b1;
          end
          OP_OUT: begin
            d.gra            = 1'b1;
            d.r_out          = 1'b1;
            d.outport_enable = 1'b1;
          end
          OP_MFHI: begin
            d.hi_out = 1'b1;
            d.gra    = 1'b1;
            d.r_in   = 1'b1;
          end
          OP_MFLO: begin
            d.lo_out = 1'b1;
            d.gra    = 1'b1;
            d.r_in   = 1'b1;
          end
          OP_ADDI: begin
            d.grb      = 1'b1;
            d.r_out    = 1'b1;
            d.y_enable = 1'b1;
          end
          default: begin
            d.grb      = 1'b1;
            d.ba_out   = 1'b1;
            d.y_enable = 1'b1;
          end
        endcase
      end
      ST_T4: begin
        d.c_sign_extended_out = 1'b1;
        d.alu_add             = 1'b1;
        d.z_enable            = 1'b1;
      end
      ST_T5: begin
        d.zlo_out = 1'b1;
        if (op == OP_LDI || op == OP_ADDI) begin
          d.gra  = 1'b1;
          d.r_in = 1'b1;
        end else begin
          d.mar_enable = 1'b1;
        end
      end
      ST_T6: begin
        d.mdr_enable = 1'b1;
        if (op == OP_ST) begin
          d.gra   = 1'b1;
          d.r_out = 1'b1;
        end else begin
          d.read = 1'b1;
        end
      end
      ST_T7: begin
        if (op == OP_ST) begin
          d.ram_write = 1'b1;
        end else begin
          d.mdr_out = 1'b1;
          d.gra     = 1'b1;
          d.r_in    = 1'b1;
        end
      end
      default: d = '0;
    endcase
    return d;
  endfunction

  // Next step: opcode latched leaving T2, instruction ends at its last step.
  always_comb begin
    w_state_nxt = r_state;
    w_op_nxt    = r_op;
    w_retire    = 1'b0;
    w_set_ill   = 1'b0;
    if (w_term) begin
      if (r_state == ST_T2) begin
        w_op_nxt = w_ir_op;
      end
      if (r_state == last_step(w_op_nxt)) begin
        w_retire    = 1'b1;
        w_set_ill   = (r_state == ST_T2) && !is_legal(w_op_nxt);
        w_state_nxt = ((r_state == ST_T2) && (w_op_nxt == OP_HALT)) ? ST_HALT : ST_T0;
      end else begin
        w_state_nxt = state_e'(STEP_W'(r_state) + STEP_W'(1));
      end
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state   <= ST_T0;
      r_op      <= OP_NOP;
      r_active  <= 1'b0;
      r_strb    <= '0;
      r_run     <= 1'b1;
      r_ill     <= 1'b0;
      r_step    <= '0;
      r_retired <= '0;
    end else begin
      r_active <= 1'b1;
      r_state  <= w_state_nxt;
      r_op     <= w_op_nxt;
      r_strb   <= decode(w_state_nxt, w_op_nxt);
      r_run    <= (w_state_nxt != ST_HALT);
      r_step   <= step_index(w_state_nxt);
      if (w_set_ill) begin
        r_ill <= 1'b1;
      end
      if (w_retire) begin
        r_retired <= r_retired + CNT_W'(1);
      end
    end
  end

  assign pc_out              = r_strb.pc_out;
  assign pc_increment        = r_strb.pc_increment;
  assign pc_enable           = r_strb.pc_enable;
  assign mar_enable          = r_strb.mar_enable;
  assign mdr_enable          = r_strb.mdr_enable;
  assign mdr_out             = r_strb.mdr_out;
  assign read                = r_strb.read;
  assign ram_write           = r_strb.ram_write;
  assign ir_enable           = r_strb.ir_enable;
  assign y_enable            = r_strb.y_enable;
  assign z_enable            = r_strb.z_enable;
  assign zlo_out             = r_strb.zlo_out;
  assign alu_add             = r_strb.alu_add;
  assign gra                 = r_strb.gra;
  assign grb                 = r_strb.grb;
  assign grc                 = r_strb.grc;
  assign r_in                = r_strb.r_in;
  assign r_out               = r_strb.r_out;
  assign ba_out              = r_strb.ba_out;
  assign c_sign_extended_out = r_strb.c_sign_extended_out;
  assign hi_out              = r_strb.hi_out;
  assign lo_out              = r_strb.lo_out;
  assign outport_enable      = r_strb.outport_enable;
  assign inport_out          = r_strb.inport_out;
  assign run                 = r_run;
  assign illegal             = r_ill;
  assign step                = r_step;
  assign retired             = r_retired;

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Hardwired, parametrised control unit for the datapath. It replaces hand-written per-instruction step sequences with a Moore FSM that fetches (T0–T2), decodes the IR opcode and drives every datapath strobe for ldi, addi, ld, st, in, out, mfhi, mflo, nop and halt. Each T-step is held for a configurable number of clocks, can be frozen by a stall input, and is followed by an instruction-retired counter.

## Interface
- `STEP_CYCLES`, default 2: clocks each T-step is held (≥1).
- `CNT_W`, default 16: width of the retired-instruction counter.
- `clk` in 1: single clock, rising edge.
- `clr` in 1: asynchronous, active-low reset.
- `ir` in 32: IR contents from the datapath; opcode = `ir[31:27]`.
- `stall` in 1: while high, the current step and its strobes are held.
- Strobes, all out 1: `pc_out` `pc_increment` `pc_enable` `mar_enable` `mdr_enable` `mdr_out` `read` `ram_write` `ir_enable` `y_enable` `z_enable` `zlo_out` `alu_add` `gra` `grb` `grc` `r_in` `r_out` `ba_out` `c_sign_extended_out` `hi_out` `lo_out` `outport_enable` `inport_out`.
- `run` out 1: high except in HALT.
- `illegal` out 1: sticky flag; set on an unsupported opcode.
- `step` out 4: current T-step index (0–7) for debug.
- `retired` out CNT_W: count of completed instructions; wraps.

## Operation
States are FETCH (T0–T2), EXEC (T3–T7) and HALT. All strobes are a decode of the registered state, step and opcode. Strobes not listed for a step are 0.

Fetch sequence:
- T0: `pc_out` `mar_enable` `pc_increment` `z_enable`.
- T1: `read` `mdr_enable` `zlo_out` `pc_enable`.
- T2: `mdr_out` `ir_enable`.

Execute sequences. The opcode is sampled from `ir` at entry to T3 and held until the instruction ends.
- ldi (00001): T3 `grb` `ba_out` `y_enable`; T4 `c_sign_extended_out` `alu_add` `z_enable`; T5 `zlo_out` `gra` `r_in`; ends.
- addi (01100): as ldi, except T3 uses `r_out` in place of `ba_out`.
- ld (00000): T3–T4 as ldi; T5 `zlo_out` `mar_enable`; T6 `read` `mdr_enable`; T7 `mdr_out` `gra` `r_in`; ends.
- st (00010): T3–T5 as ld; T6 `gra` `r_out` `mdr_enable` with `read`=0; T7 `ram_write`; ends.
- in (10110): T3 `inport_out` `gra` `r_in`.
- out (10111): T3 `gra` `r_out` `outport_enable`.
- mfhi (11000): T3 `hi_out` `gra` `r_in`.
- mflo (11001): T3 `lo_out` `gra` `r_in`.
- nop (11010): ends after T2, with no EXEC steps.
- halt (11011): enters HALT after T2 and increments `retired`.
- Any other opcode: treated as nop, and `illegal` is set.

HALT: all strobes 0 and `run`=0. HALT is exited only by reset.

`retired` increments on the final clock of the last step of each instruction.

## Timing
- Reset (`clr` low, asynchronous): state=T0, step counter=0, all strobes 0, `run`=1, `illegal`=0, `retired`=0.
  - On `clr` release, T0 strobes appear from the first clock.
  - A reset mid-instruction aborts it; no partial `retired` increment.
- Step timer: counts 0..STEP_CYCLES-1. The step advances on the clock edge where count==STEP_CYCLES-1 and `stall`=0.
- `stall`=1 freezes the timer and holds the strobes. Held strobes are idempotent because datapath inputs are stable within a step.
- `stall` in HALT is ignored.
- Instruction latency is steps×STEP_CYCLES clocks, excluding stalls:
  - nop: 3 steps.
  - in, out, mfhi, mflo: 4 steps.
  - ldi, addi: 6 steps.
  - ld, st: 8 steps.
- With STEP_CYCLES=1, each step is exactly one clock; no idle clock is inserted between instructions.
- `retired` wraps from 2^CNT_W−1 to 0.

## Structure
- Package `cpu_ctrl_pkg`: opcode localparams, state enum (T0–T7, HALT), step index constants.
- Sub-module `step_timer`: parametrised count/terminal pulse with stall hold.
- The remainder is a single FSM and strobe-decode module.

## Test plan
- STEP_CYCLES=2, `ir`=0x0A800005 (ldi R5, 5 relative to R0): T0..T5 each last 2 clocks; T4 has `c_sign_extended_out`=`z_enable`=`alu_add`=1; T5 has `gra`=`r_in`=`zlo_out`=1; `retired`=1 after 12 clocks.
- `ir` opcode 10111 (out): T3 `outport_enable`=`gra`=`r_out`=1 for 2 clocks; `retired` increments at clock 8.
- st with `stall` raised for 3 clocks during T6: T6 lasts 5 clocks with strobes held; `ram_write` only in T7; total 19 clocks.
- Opcode 11111: only T0–T2 run; `illegal`=1 and stays 1; `retired` increments.
- halt: `run` falls after T2 and strobes stay 0 for 20+ clocks; `clr` low returns to T0 with `run`=1.
- STEP_CYCLES=1, CNT_W=2, five consecutive nops: `retired` sequence 1,2,3,0,1 at 3-clock intervals; `clr` asserted mid-T1 clears all outputs immediately.
